// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence path (serializer + detector).
// Holds the serializer FSM encoding, the default pattern width, the tick
// counter width and the detector's state encoding.
package seq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned TICK_W     = 8;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ser_state_t;

  // Sequence detector states (consumer of seq_out)
  typedef enum logic [2:0] {
    DET_S0    = 3'd0,
    DET_S1    = 3'd1,
    DET_S11   = 3'd2,
    DET_S110  = 3'd3,
    DET_S1101 = 3'd4
  } det_state_t;

endpackage

// File: rtl/seq_tick_gen.sv
// Bit-period divider: tick is high in the last cycle of every TICK_DIV-cycle
// period while run=1; the counter is held at zero while run=0.
// Ports: clk, reset (async active-low), run (enable), tick (period end).
module seq_tick_gen
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam logic [TICK_W-1:0] TERM = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  // Combinational so the serializer can act in the same cycle the period ends
  assign tick = run && (cnt == TERM);

  // Period counter; restarts on each tick so it never passes TERM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// MSB-first pattern serializer feeding the sequence detector.
// Accepts load_data on load_valid & load_ready (IDLE only), shifts it out on
// seq_out holding each bit TICK_DIV cycles with a bit_strobe in each bit's
// first cycle, then pulses done for one cycle before returning to IDLE.
// Ports: clk, reset (async active-low), load_data/load_valid/load_ready
// (pattern handshake), seq_out, bit_strobe, busy, done.
// Optional: define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              seq_out,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
);

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif
  localparam int unsigned CNT_W = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS);

  ser_state_t        state, state_d;
  // Bits still to send after the one on seq_out, next bit at the top
  logic [DATA_W-2:0] shreg, shreg_d;
  // Number of bits presented so far for the current pattern
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic              seq_out_d, strobe_d, ready_d, busy_d, done_d;
  logic              tick;

`ifdef SEQ_SERIALIZER_PARITY_EN
  logic              par, par_d;
`endif

  seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (state == ST_SHIFT),
    .tick  (tick)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
    seq_out_d = 1'b0;
    strobe_d  = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    par_d     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (load_valid && load_ready) begin
          state_d   = ST_SHIFT;
          shreg_d   = load_data[DATA_W-2:0];
          bit_cnt_d = CNT_W'(1);
          seq_out_d = load_data[DATA_W-1];
          strobe_d  = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
          par_d     = ^load_data;
`endif
        end
      end
      ST_SHIFT: begin
        seq_out_d = seq_out;
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_d   = ST_DONE;
            bit_cnt_d = '0;
            seq_out_d = 1'b0;
          end else begin
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt + CNT_W'(1);
            seq_out_d = shreg[DATA_W-2];
            strobe_d  = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            // After the LSB, the parity bit takes the next slot
            if (bit_cnt == CNT_W'(DATA_W)) seq_out_d = par;
`endif
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_SHIFT);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; load_ready resets low and rises
  // on the first edge after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      load_ready <= 1'b0;
      seq_out    <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      shreg      <= shreg_d;
      bit_cnt    <= bit_cnt_d;
      load_ready <= ready_d;
      seq_out    <= seq_out_d;
      bit_strobe <= strobe_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

`ifdef SEQ_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par <= 1'b0;
    end else begin
      par <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: one instance with TICK_DIV=1 and
// one with TICK_DIV=3, driven from a table of patterns with hand-computed
// serial streams, parity bits and 1101-detector hit counts, plus directed
// sequences for reset behaviour, load_valid held during SHIFT and mid-pattern
// reset.
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       reset [2];
  logic [7:0] load_data [2];
  logic       load_valid [2];
  logic       load_ready [2];
  logic       seq_out [2];
  logic       bit_strobe [2];
  logic       busy [2];
  logic       done [2];

  always #5 clk = ~clk;

  seq_serializer #(.DATA_W(8), .TICK_DIV(1)) u_div1 (
    .clk(clk), .reset(reset[0]), .load_data(load_data[0]),
    .load_valid(load_valid[0]), .load_ready(load_ready[0]),
    .seq_out(seq_out[0]), .bit_strobe(bit_strobe[0]),
    .busy(busy[0]), .done(done[0])
  );

  seq_serializer #(.DATA_W(8), .TICK_DIV(3)) u_div3 (
    .clk(clk), .reset(reset[1]), .load_data(load_data[1]),
    .load_valid(load_valid[1]), .load_ready(load_ready[1]),
    .seq_out(seq_out[1]), .bit_strobe(bit_strobe[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct {
    logic [7:0] data;
    logic       par;   // even parity of data
    int         det;   // expected 1101 detections over the sent stream
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] exp_stream(input vec_t v);
`ifdef SEQ_SERIALIZER_PARITY_EN
    return {v.data, v.par};
`else
    return {1'b0, v.data};
`endif
  endfunction

  // Offer one pattern to instance d and observe it until the cycle after done
  task automatic send(input int d, input logic [7:0] data, input logic hold_next,
                      input logic [7:0] next_data, output logic [8:0] stream,
                      output int nstrobe, output int nbusy, output int done_cyc,
                      output int det_hits, output int spacing_bad);
    int waited;
    int last;
    int div;
    logic [3:0] hist;
    div = (d == 0) ? 1 : 3;
    stream = '0; nstrobe = 0; nbusy = 0; done_cyc = 0; det_hits = 0;
    spacing_bad = 0; hist = '0; last = 0; waited = 0;
    while (load_ready[d] !== 1'b1 && waited < 50) begin
      next_cyc();
      waited++;
    end
    check($sformatf("ready_wait d%0d", d), 32'(waited < 50), 32'd1);
    load_data[d]  = data;
    load_valid[d] = 1'b1;
    next_cyc();
    if (hold_next) load_data[d] = next_data;
    else load_valid[d] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (done[d] === 1'b1) begin
        done_cyc = c;
        check($sformatf("done_outs d%0d", d),
              {28'd0, load_ready[d], seq_out[d], bit_strobe[d], busy[d]}, 32'd0);
        break;
      end
      if (busy[d] === 1'b1) nbusy++;
      if (bit_strobe[d] === 1'b1) begin
        if (nstrobe > 0 && (c - last) != div) spacing_bad++;
        if (busy[d] !== 1'b1) spacing_bad++;
        last = c;
        nstrobe++;
        stream = {stream[7:0], seq_out[d]};
        hist   = {hist[2:0], seq_out[d]};
        if (nstrobe >= 4 && hist == 4'b1101) det_hits++;
      end
      next_cyc();
    end
    next_cyc();
    check($sformatf("post_done d%0d", d),
          {29'd0, load_ready[d], done[d], busy[d]}, 32'b100);
  endtask

  task automatic run_vec(input int d, input vec_t v, input logic hold_next,
                         input logic [7:0] next_data);
    logic [8:0] stream;
    int ns, nb, dc, dh, sb, div;
    div = (d == 0) ? 1 : 3;
    send(d, v.data, hold_next, next_data, stream, ns, nb, dc, dh, sb);
    check($sformatf("stream d%0d %02h", d, v.data), 32'(stream), 32'(exp_stream(v)));
    check($sformatf("strobes d%0d %02h", d, v.data), 32'(ns), 32'(NB));
    check($sformatf("busy_cyc d%0d %02h", d, v.data), 32'(nb), 32'(NB * div));
    check($sformatf("done_cyc d%0d %02h", d, v.data), 32'(dc), 32'(NB * div + 1));
    check($sformatf("spacing d%0d %02h", d, v.data), 32'(sb), 32'd0);
    check($sformatf("detect d%0d %02h", d, v.data), 32'(dh), 32'(v.det));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    vecs[0] = '{8'hD0, 1'b1, 1};
    vecs[1] = '{8'hA5, 1'b0, 0};
    vecs[2] = '{8'h0F, 1'b0, 0};
    vecs[3] = '{8'h01, 1'b1, 0};
    vecs[4] = '{8'h80, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b0, 0};
    vecs[6] = '{8'h00, 1'b0, 0};
    vecs[7] = '{8'h07, 1'b1, 0};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; load_valid[d] = 1'b1; load_data[d] = 8'hD0;
    end
    #2;
    for (int d = 0; d < 2; d++) reset[d] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("async_reset d%0d", d),
            {27'd0, load_ready[d], seq_out[d], bit_strobe[d], busy[d], done[d]}, 32'd0);
    next_cyc(); next_cyc(); next_cyc();
    for (int d = 0; d < 2; d++)
      check($sformatf("in_reset d%0d", d),
            {27'd0, load_ready[d], seq_out[d], bit_strobe[d], busy[d], done[d]}, 32'd0);

    // Release with load_valid already high: no capture on the first edge
    for (int d = 0; d < 2; d++) reset[d] = 1'b1;
    next_cyc();
    for (int d = 0; d < 2; d++)
      check($sformatf("first_after_reset d%0d", d),
            {28'd0, load_ready[d], busy[d], seq_out[d], done[d]}, 32'b1000);
    for (int d = 0; d < 2; d++) load_valid[d] = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(0, vecs[i], 1'b0, 8'h00);
    run_vec(1, vecs[1], 1'b0, 8'h00);
    run_vec(1, vecs[0], 1'b0, 8'h00);

    // load_valid held with 8'hFF across a 8'h0F transfer
    run_vec(0, vecs[2], 1'b1, 8'hFF);
    check("hold_valid_kept", 32'(load_valid[0]), 32'd1);
    run_vec(0, vecs[5], 1'b0, 8'h00);

    // Reset during the 4th bit of 8'hD0 (that bit is 1)
    load_data[0] = 8'hD0; load_valid[0] = 1'b1;
    next_cyc();
    load_valid[0] = 1'b0;
    next_cyc(); next_cyc(); next_cyc();
    check("bit4_before_reset", {30'd0, busy[0], seq_out[0]}, 32'b11);
    #2;
    reset[0] = 1'b0;
    #1;
    check("mid_shift_reset",
          {27'd0, load_ready[0], seq_out[0], bit_strobe[0], busy[0], done[0]}, 32'd0);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      if (done[0] !== 1'b0) dones++;
    end
    reset[0] = 1'b1;
    next_cyc();
    check("ready_after_mid_reset", {30'd0, load_ready[0], busy[0]}, 32'b10);
    for (int k = 0; k < 12; k++) begin
      if (done[0] !== 1'b0) dones++;
      next_cyc();
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    run_vec(0, vecs[1], 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pattern width in bits, legal range 2..32.
REQ-002 SHALL have parameter TICK_DIV, default 1: clock cycles per serial bit, legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_data  input  DATA_W  pattern to send, MSB first.
REQ-006 SHALL have port load_valid  input  1  producer offers load_data.
REQ-007 SHALL have port load_ready  output  1  block accepts a pattern this cycle.
REQ-008 SHALL have port seq_out  output  1  serial bit stream; drives the sequence detector's seq_in.
REQ-009 SHALL have port bit_strobe  output  1  one-cycle pulse in the first cycle of each new bit on seq_out.
REQ-010 SHALL have port busy  output  1  high while bits are being shifted.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last bit period ends.

Function
REQ-012 SHALL implement states IDLE, SHIFT, DONE.
REQ-013 SHALL drive load_ready=1 only in IDLE; acceptance = load_valid & load_ready on a rising edge.
REQ-014 SHALL, on acceptance, capture load_data into a shift register and enter SHIFT; the MSB appears on seq_out, with bit_strobe=1, in the very next cycle.
REQ-015 SHALL hold each bit on seq_out for exactly TICK_DIV cycles, then present the next lower bit with bit_strobe=1.
REQ-016 SHALL, with TICK_DIV=1, present one new bit every cycle, so bit_strobe stays high throughout SHIFT.
REQ-017 SHALL, after the final bit's period, enter DONE for exactly one cycle: done=1, seq_out=0, busy=0, load_ready=0; then return to IDLE.
REQ-018 SHALL drive seq_out=0, bit_strobe=0 and busy=0 in IDLE and DONE; busy=1 in every SHIFT cycle.
REQ-019 SHALL ignore load_valid in SHIFT and DONE: no capture, no change to the in-flight pattern.
REQ-020 SHALL keep the bit counter width at clog2(DATA_W+2) and the tick counter width at 8 bits; counters do not wrap past their terminal count.
REQ-021 SHALL, for one pattern, use DATA_W*TICK_DIV cycles in SHIFT (more when REQ-027 applies) and DONE+IDLE = 2 cycles before the next acceptance.

Reset
REQ-022 SHALL, while reset=0, force state to IDLE and clear both counters and the shift register, regardless of clk.
REQ-023 SHALL, while reset=0, hold load_ready=0, seq_out=0, bit_strobe=0, busy=0 and done=0.
REQ-024 SHALL hold load_ready=1 in the first cycle after reset deasserts.
REQ-025 SHALL, on reset mid-SHIFT, abandon the pattern; no done pulse is generated for it.

Configuration
REQ-026 SHALL use macro SEQ_SERIALIZER_PARITY_EN.
REQ-027 SHALL, with SEQ_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the captured pattern) after the LSB, held TICK_DIV cycles with its own bit_strobe, making SHIFT last (DATA_W+1)*TICK_DIV cycles.
REQ-028 SHALL, without the macro, send exactly DATA_W bits and contain no parity logic.

Structure
REQ-029 SHALL place the state enumeration (IDLE/SHIFT/DONE encodings) and the DATA_W default constant in shared package seq_pkg, alongside the detector's state constants.
REQ-030 SHALL implement the bit-period divider as sub-module seq_tick_gen (inputs clk, reset, run; output tick every TICK_DIV cycles while run=1, counter cleared when run=0).

Verification
REQ-031 SHALL cover: reset released, load_data=8'b11010000, load_valid=1, TICK_DIV=1 -> seq_out=1,1,0,1,0,0,0,0 on cycles 1-8 after acceptance, done=1 on cycle 9, load_ready=1 on cycle 10.
REQ-032 SHALL cover: same pattern chained into the detector -> detector output high exactly once within the 8-bit window.
REQ-033 SHALL cover: TICK_DIV=3, load_data=8'hA5 -> each bit held 3 cycles, 8 bit_strobe pulses spaced 3 cycles apart, busy high for 24 cycles.
REQ-034 SHALL cover: load_valid held high with a new value 8'hFF during SHIFT -> the in-flight pattern 8'h0F is unchanged and 8'hFF is accepted only in the next IDLE.
REQ-035 SHALL cover: reset pulled low in the 4th bit -> all outputs 0 immediately, no done pulse, load_ready=1 in the first cycle after release.
REQ-036 SHALL cover: SEQ_SERIALIZER_PARITY_EN defined, load_data=8'h07 -> ninth bit 1, done on cycle 10 after acceptance.
